// File: rtl/wb_resp_pkg.sv
// -----------------------------------------------------------------------------
// wb_resp_pkg
// Shared types and helpers for the Wishbone classic bus responder.
//   resp_state_e    : per-channel FSM state (IDLE / WAIT / RESP)
//   wait_cnt_width(): bits needed for a wait counter that counts 0..max_wait,
//                     never less than 1 so MAX_WAIT=0 still gives a legal vector
// -----------------------------------------------------------------------------
package wb_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    function automatic int wait_cnt_width(input int max_wait);
        int w;
        w = $clog2(max_wait + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_resp_channel.sv
// -----------------------------------------------------------------------------
// wb_resp_channel
// One Wishbone classic slave responder channel: request FSM with bounded,
// externally chosen wait states, request capture, protocol checker and
// saturating transaction/abort counters.
// Ports:
//   clock, reset_n       : clock, asynchronous active-low reset
//   i_cyc/i_stb/i_we     : master control
//   i_adr/i_sel/i_dat    : master address, byte select, write data
//   i_rand_ack/i_rand_err: choice to respond now / respond with ERR
//   i_rand_data          : read data offered in the decision cycle
//   o_ack/o_err/o_dat    : registered response (high only in RESP)
//   o_violation          : sticky master protocol violation
//   o_txn_count          : completed responses, saturating
//   o_abort_count        : CYC drops while a request was pending, saturating
// -----------------------------------------------------------------------------
module wb_resp_channel
    import wb_resp_pkg::*;
#(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int MAX_WAIT   = 3,
    parameter int ERR_ENABLE = 0,
    parameter int CNT_W      = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                i_cyc,
    input  logic                i_stb,
    input  logic                i_we,
    input  logic [ADDR_W-1:0]   i_adr,
    input  logic [DATA_W/8-1:0] i_sel,
    input  logic [DATA_W-1:0]   i_dat,
    input  logic                i_rand_ack,
    input  logic                i_rand_err,
    input  logic [DATA_W-1:0]   i_rand_data,
    output logic                o_ack,
    output logic                o_err,
    output logic [DATA_W-1:0]   o_dat,
    output logic                o_violation,
    output logic [CNT_W-1:0]    o_txn_count,
    output logic [CNT_W-1:0]    o_abort_count
);

    localparam int                SEL_W   = DATA_W / 8;
    localparam int                WAIT_W  = wait_cnt_width(MAX_WAIT);
    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    resp_state_e         r_state;
    resp_state_e         w_state_next;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_next;

    logic [ADDR_W-1:0]   r_adr;
    logic                r_we;
    logic [SEL_W-1:0]    r_sel;
    logic [DATA_W-1:0]   r_dat;

    logic                r_ack;
    logic                r_err;
    logic [DATA_W-1:0]   r_dat_miso;
    logic                r_violation;
    logic [CNT_W-1:0]    r_txn_count;
    logic [CNT_W-1:0]    r_abort_count;

    logic                w_req;
    logic                w_is_err;
    logic                w_capture;
    logic                w_respond;
    logic                w_abort;
    logic                w_resp_we;
    logic                w_viol_now;

    assign w_req    = i_cyc & i_stb;
    assign w_is_err = (ERR_ENABLE != 0) & i_rand_err;

    // Next-state logic. In IDLE the wait count is taken as zero, so only
    // MAX_WAIT=0 forces an immediate response without rand_ack.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;
        w_capture    = 1'b0;
        w_respond    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_capture = 1'b1;
                    if (i_rand_ack || (MAX_WAIT == 0)) begin
                        w_state_next = RESP;
                        w_respond    = 1'b1;
                        w_wait_next  = '0;
                    end else begin
                        w_state_next = WAIT;
                        w_wait_next  = WAIT_W'(1);
                    end
                end
            end
            WAIT: begin
                // Abort has priority over a simultaneous response decision.
                if (!i_cyc) begin
                    w_state_next = IDLE;
                    w_abort      = 1'b1;
                    w_wait_next  = '0;
                end else if (i_rand_ack || (r_wait_cnt == MAX_CNT)) begin
                    w_state_next = RESP;
                    w_respond    = 1'b1;
                    w_wait_next  = '0;
                end else begin
                    w_wait_next  = r_wait_cnt + WAIT_W'(1);
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_wait_next  = '0;
            end
        endcase
    end

    // The direction of the request being answered: live in IDLE (it is
    // captured in that same cycle), the captured copy in WAIT.
    assign w_resp_we = (r_state == IDLE) ? i_we : r_we;

    assign w_viol_now = (i_stb & ~i_cyc)
                      | ((r_state == WAIT) & i_cyc &
                         (~i_stb | (i_adr != r_adr) | (i_we != r_we) |
                          (i_sel != r_sel) | (i_dat != r_dat)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_adr <= '0;
            r_we  <= 1'b0;
            r_sel <= '0;
            r_dat <= '0;
        end else if (w_capture) begin
            r_adr <= i_adr;
            r_we  <= i_we;
            r_sel <= i_sel;
            r_dat <= i_dat;
        end
    end

    // Response registers are loaded only on the transition into RESP, so
    // they are zero in every other state without extra gating.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_dat_miso <= '0;
        end else begin
            r_ack      <= w_respond & ~w_is_err;
            r_err      <= w_respond & w_is_err;
            r_dat_miso <= (w_respond && !w_is_err && !w_resp_we) ? i_rand_data : '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_violation   <= 1'b0;
            r_txn_count   <= '0;
            r_abort_count <= '0;
        end else begin
            r_violation <= r_violation | w_viol_now;
            if ((r_state == RESP) && (r_txn_count != '1)) begin
                r_txn_count <= r_txn_count + CNT_W'(1);
            end
            if (w_abort && (r_abort_count != '1)) begin
                r_abort_count <= r_abort_count + CNT_W'(1);
            end
        end
    end

    assign o_ack         = r_ack;
    assign o_err         = r_err;
    assign o_dat         = r_dat_miso;
    assign o_violation   = r_violation;
    assign o_txn_count   = r_txn_count;
    assign o_abort_count = r_abort_count;

endmodule

// File: rtl/wb_bus_responder.sv
// -----------------------------------------------------------------------------
// wb_bus_responder
// Multi-channel Wishbone classic slave responder. Each channel is an
// independent wb_resp_channel; channel c uses slice [c*W +: W] of every
// packed vector.
// Ports:
//   clock, reset_n                 : clock, asynchronous active-low reset
//   wb_cyc/stb/we/adr/sel/dat_mosi : master request per channel
//   rand_ack/rand_err/rand_data    : response choices per channel
//   wb_ack/wb_err/wb_dat_miso      : registered responses
//   violation                      : sticky protocol-violation flags
//   txn_count/abort_count          : saturating per-channel counters
// -----------------------------------------------------------------------------
module wb_bus_responder
    import wb_resp_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int ADDR_W       = 30,
    parameter int DATA_W       = 32,
    parameter int MAX_WAIT     = 3,
    parameter int ERR_ENABLE   = 0,
    parameter int CNT_W        = 16
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [NUM_CHANNELS-1:0]          wb_cyc,
    input  logic [NUM_CHANNELS-1:0]          wb_stb,
    input  logic [NUM_CHANNELS-1:0]          wb_we,
    input  logic [NUM_CHANNELS*ADDR_W-1:0]   wb_adr,
    input  logic [NUM_CHANNELS*DATA_W/8-1:0] wb_sel,
    input  logic [NUM_CHANNELS*DATA_W-1:0]   wb_dat_mosi,
    input  logic [NUM_CHANNELS-1:0]          rand_ack,
    input  logic [NUM_CHANNELS-1:0]          rand_err,
    input  logic [NUM_CHANNELS*DATA_W-1:0]   rand_data,
    output logic [NUM_CHANNELS-1:0]          wb_ack,
    output logic [NUM_CHANNELS-1:0]          wb_err,
    output logic [NUM_CHANNELS*DATA_W-1:0]   wb_dat_miso,
    output logic [NUM_CHANNELS-1:0]          violation,
    output logic [NUM_CHANNELS*CNT_W-1:0]    txn_count,
    output logic [NUM_CHANNELS*CNT_W-1:0]    abort_count
);

    localparam int SEL_W = DATA_W / 8;

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
        wb_resp_channel #(
            .ADDR_W     (ADDR_W),
            .DATA_W     (DATA_W),
            .MAX_WAIT   (MAX_WAIT),
            .ERR_ENABLE (ERR_ENABLE),
            .CNT_W      (CNT_W)
        ) u_channel (
            .clock         (clock),
            .reset_n       (reset_n),
            .i_cyc         (wb_cyc[gi]),
            .i_stb         (wb_stb[gi]),
            .i_we          (wb_we[gi]),
            .i_adr         (wb_adr[gi*ADDR_W +: ADDR_W]),
            .i_sel         (wb_sel[gi*SEL_W +: SEL_W]),
            .i_dat         (wb_dat_mosi[gi*DATA_W +: DATA_W]),
            .i_rand_ack    (rand_ack[gi]),
            .i_rand_err    (rand_err[gi]),
            .i_rand_data   (rand_data[gi*DATA_W +: DATA_W]),
            .o_ack         (wb_ack[gi]),
            .o_err         (wb_err[gi]),
            .o_dat         (wb_dat_miso[gi*DATA_W +: DATA_W]),
            .o_violation   (violation[gi]),
            .o_txn_count   (txn_count[gi*CNT_W +: CNT_W]),
            .o_abort_count (abort_count[gi*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_wb_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_wb_bus_responder
// Two responders share one stimulus: dut_a (ERR_ENABLE=1, 16-bit counters)
// and dut_b (ERR_ENABLE=0, 2-bit counters), both MAX_WAIT=3. Each table row
// holds the inputs for one cycle and the outputs expected after the next
// rising edge. Hand-written sequences follow for violation stickiness,
// counter saturation, asynchronous reset and post-reset latency.
// -----------------------------------------------------------------------------
module tb_wb_bus_responder;

    logic        clock;
    logic        reset_n;
    logic [1:0]  cyc, stb, we, rack, rerr;
    logic [59:0] adr;
    logic [7:0]  sel;
    logic [63:0] mosi, rdata;

    logic [1:0]  ack_a, err_a, viol_a, ack_b, err_b, viol_b;
    logic [63:0] miso_a, miso_b;
    logic [31:0] txn_a, abort_a;
    logic [3:0]  txn_b, abort_b;

    int n_tests = 0;
    int n_fail  = 0;

    wb_bus_responder #(
        .NUM_CHANNELS(2), .ADDR_W(30), .DATA_W(32),
        .MAX_WAIT(3), .ERR_ENABLE(1), .CNT_W(16)
    ) dut_a (
        .clock(clock), .reset_n(reset_n),
        .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr), .wb_sel(sel),
        .wb_dat_mosi(mosi), .rand_ack(rack), .rand_err(rerr), .rand_data(rdata),
        .wb_ack(ack_a), .wb_err(err_a), .wb_dat_miso(miso_a),
        .violation(viol_a), .txn_count(txn_a), .abort_count(abort_a)
    );

    wb_bus_responder #(
        .NUM_CHANNELS(2), .ADDR_W(30), .DATA_W(32),
        .MAX_WAIT(3), .ERR_ENABLE(0), .CNT_W(2)
    ) dut_b (
        .clock(clock), .reset_n(reset_n),
        .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr), .wb_sel(sel),
        .wb_dat_mosi(mosi), .rand_ack(rack), .rand_err(rerr), .rand_data(rdata),
        .wb_ack(ack_b), .wb_err(err_b), .wb_dat_miso(miso_b),
        .violation(viol_b), .txn_count(txn_b), .abort_count(abort_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic        we0;
        logic [29:0] adr1;
        logic [1:0]  rack;
        logic [1:0]  rerr;
        logic [31:0] rdata;
        logic [1:0]  e_ack_a;
        logic [1:0]  e_err_a;
        logic [31:0] e_miso_a;
        logic [1:0]  e_ack_b;
        logic [31:0] e_miso_b;
        logic [15:0] e_txn;
        logic [15:0] e_abort;
        logic [1:0]  e_viol;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [1:0] c, input logic [1:0] s, input logic w,
        input logic [29:0] a1, input logic [1:0] ra, input logic [1:0] re,
        input logic [31:0] d, input logic [1:0] ea, input logic [1:0] ee,
        input logic [31:0] em, input logic [1:0] eab, input logic [31:0] emb,
        input int t, input int ab, input logic [1:0] ev);
        vec_t v;
        v.cyc = c; v.stb = s; v.we0 = w; v.adr1 = a1; v.rack = ra; v.rerr = re;
        v.rdata = d; v.e_ack_a = ea; v.e_err_a = ee; v.e_miso_a = em;
        v.e_ack_b = eab; v.e_miso_b = emb; v.e_txn = 16'(t); v.e_abort = 16'(ab);
        v.e_viol = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; ch0 address/sel/write data stay constant
    // so that only the table's ch1 address can provoke a capture mismatch.
    task automatic drive(input logic [1:0] c, input logic [1:0] s, input logic w,
                         input logic [29:0] a1, input logic [1:0] ra,
                         input logic [1:0] re, input logic [31:0] d);
        cyc   = c;
        stb   = s;
        we    = {1'b0, w};
        adr   = {a1, 30'h100};
        sel   = 8'hFF;
        mosi  = {32'h0BAD_CAFE, 32'hCAFE_F00D};
        rack  = ra;
        rerr  = re;
        rdata = {~d, d};
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 1'b0, 30'h200, 2'b00, 2'b00, 32'h0);
    endtask

    initial begin
        logic [15:0] exp_b;

        reset_n = 1'b0;
        idle();

        // Row order: cyc stb we0 adr1 rack rerr rdata | ack_a err_a miso_a ack_b miso_b txn abort viol
        // Minimum latency read
        tbl.push_back(mk(2'b01,2'b01,0,30'h200,2'b01,2'b00,32'hDEADBEEF, 2'b01,2'b00,32'hDEADBEEF, 2'b01,32'hDEADBEEF, 0,0,2'b00));
        tbl.push_back(mk(2'b01,2'b01,0,30'h200,2'b00,2'b00,32'h11111111, 2'b00,2'b00,32'h0, 2'b00,32'h0, 1,0,2'b00));
        tbl.push_back(mk(2'b00,2'b00,0,30'h200,2'b00,2'b00,32'h22222222, 2'b00,2'b00,32'h0, 2'b00,32'h0, 1,0,2'b00));
        // Maximum latency: rand_ack held low, forced at wait_cnt==3
        tbl.push_back(mk(2'b01,2'b01,0,30'h200,2'b00,2'b00,32'h33333333, 2'b00,2'b00,32'h0, 2'b00,32'h0, 1,0,2'b00));
        tbl.push_back(mk(2'b01,2'b01,0,30'h200,2'b00,2'b00,32'h44444444, 2'b00,2'b00,32'h0, 2'b00,32'h0, 1,0,2'b00));
        tbl.push_back(mk(2'b01,2'b01,0,30'h200,2'b00,2'b00,32'h55555555, 2'b00,2'b00,32'h0, 2'b00,32'h0, 1,0,2'b00));
        tbl.push_back(mk(2'b01,2'b01,0,30'h200,2'b00,2'b00,32'h12345678, 2'b01,2'b00,32'h12345678, 2'b01,32'h12345678, 1,0,2'b00));
        tbl.push_back(mk(2'b01,2'b01,0,30'h200,2'b00,2'b00,32'h77777777, 2'b00,2'b00,32'h0, 2'b00,32'h0, 2,0,2'b00));
        tbl.push_back(mk(2'b00,2'b00,0,30'h200,2'b00,2'b00,32'h88888888, 2'b00,2'b00,32'h0, 2'b00,32'h0, 2,0,2'b00));
        // ERR vs ACK at t=2 of a wait
        tbl.push_back(mk(2'b01,2'b01,0,30'h200,2'b00,2'b00,32'h99999999, 2'b00,2'b00,32'h0, 2'b00,32'h0, 2,0,2'b00));
        tbl.push_back(mk(2'b01,2'b01,0,30'h200,2'b00,2'b00,32'hAAAAAAAA, 2'b00,2'b00,32'h0, 2'b00,32'h0, 2,0,2'b00));
        tbl.push_back(mk(2'b01,2'b01,0,30'h200,2'b01,2'b01,32'h0BADF00D, 2'b00,2'b01,32'h0, 2'b01,32'h0BADF00D, 2,0,2'b00));
        tbl.push_back(mk(2'b01,2'b01,0,30'h200,2'b00,2'b00,32'hCCCCCCCC, 2'b00,2'b00,32'h0, 2'b00,32'h0, 3,0,2'b00));
        tbl.push_back(mk(2'b00,2'b00,0,30'h200,2'b00,2'b00,32'hDDDDDDDD, 2'b00,2'b00,32'h0, 2'b00,32'h0, 3,0,2'b00));
        // Abort: cyc drops at t=2 with rand_ack=1
        tbl.push_back(mk(2'b01,2'b01,0,30'h200,2'b00,2'b00,32'hEEEEEEEE, 2'b00,2'b00,32'h0, 2'b00,32'h0, 3,0,2'b00));
        tbl.push_back(mk(2'b01,2'b01,0,30'h200,2'b00,2'b00,32'hFFFFFFFF, 2'b00,2'b00,32'h0, 2'b00,32'h0, 3,0,2'b00));
        tbl.push_back(mk(2'b00,2'b00,0,30'h200,2'b01,2'b00,32'h13131313, 2'b00,2'b00,32'h0, 2'b00,32'h0, 3,1,2'b00));
        tbl.push_back(mk(2'b00,2'b00,0,30'h200,2'b01,2'b01,32'h17171717, 2'b00,2'b00,32'h0, 2'b00,32'h0, 3,1,2'b00));
        // Write: ACK with zero read data
        tbl.push_back(mk(2'b01,2'b01,1,30'h200,2'b01,2'b00,32'hAAAA5555, 2'b01,2'b00,32'h0, 2'b01,32'h0, 3,1,2'b00));
        tbl.push_back(mk(2'b01,2'b01,1,30'h200,2'b00,2'b00,32'h19191919, 2'b00,2'b00,32'h0, 2'b00,32'h0, 4,1,2'b00));
        tbl.push_back(mk(2'b00,2'b00,0,30'h200,2'b00,2'b00,32'h20202020, 2'b00,2'b00,32'h0, 2'b00,32'h0, 4,1,2'b00));
        // ch1 address changes during WAIT
        tbl.push_back(mk(2'b10,2'b10,0,30'h200,2'b00,2'b00,32'h21212121, 2'b00,2'b00,32'h0, 2'b00,32'h0, 4,1,2'b00));
        tbl.push_back(mk(2'b10,2'b10,0,30'h201,2'b00,2'b00,32'h22222222, 2'b00,2'b00,32'h0, 2'b00,32'h0, 4,1,2'b10));
        tbl.push_back(mk(2'b00,2'b00,0,30'h200,2'b00,2'b00,32'h23232323, 2'b00,2'b00,32'h0, 2'b00,32'h0, 4,1,2'b10));

        // Reset state
        step();
        step();
        chk("rst_ack",   32'({err_a, ack_a, err_b, ack_b}), 32'h0);
        chk("rst_miso",  miso_a[31:0] | miso_a[63:32], 32'h0);
        chk("rst_cnt",   txn_a | abort_a, 32'h0);
        chk("rst_viol",  32'({viol_a, viol_b}), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].cyc, tbl[i].stb, tbl[i].we0, tbl[i].adr1,
                  tbl[i].rack, tbl[i].rerr, tbl[i].rdata);
            step();
            exp_b = (tbl[i].e_txn > 16'd3) ? 16'd3 : tbl[i].e_txn;
            $display("[TB] vec %0d ack_a=%b err_a=%b miso_a=%h ack_b=%b txn=%0d abort=%0d viol=%b",
                     i, ack_a, err_a, miso_a[31:0], ack_b, txn_a[15:0], abort_a[15:0], viol_a);
            chk($sformatf("v%0d_ack_a", i),   32'(ack_a), 32'(tbl[i].e_ack_a));
            chk($sformatf("v%0d_err_a", i),   32'(err_a), 32'(tbl[i].e_err_a));
            chk($sformatf("v%0d_miso_a", i),  miso_a[31:0], tbl[i].e_miso_a);
            chk($sformatf("v%0d_miso1_a", i), miso_a[63:32], 32'h0);
            chk($sformatf("v%0d_ack_b", i),   32'(ack_b), 32'(tbl[i].e_ack_b));
            chk($sformatf("v%0d_err_b", i),   32'(err_b), 32'h0);
            chk($sformatf("v%0d_miso_b", i),  miso_b[31:0], tbl[i].e_miso_b);
            chk($sformatf("v%0d_txn_a", i),   32'(txn_a[15:0]), 32'(tbl[i].e_txn));
            chk($sformatf("v%0d_txn_b", i),   32'(txn_b[1:0]), 32'(exp_b));
            chk($sformatf("v%0d_abort_a", i), 32'(abort_a[15:0]), 32'(tbl[i].e_abort));
            chk($sformatf("v%0d_viol_a", i),  32'(viol_a), 32'(tbl[i].e_viol));
            chk($sformatf("v%0d_viol_b", i),  32'(viol_b), 32'(tbl[i].e_viol));
        end

        // Violation stays set through 10 idle cycles
        idle();
        repeat (10) step();
        $display("[TB] sticky viol_a=%b viol_b=%b", viol_a, viol_b);
        chk("viol_sticky_a", 32'(viol_a), 32'h2);
        chk("viol_sticky_b", 32'(viol_b), 32'h2);

        // Fifth transaction: 16-bit counter reaches 5, 2-bit counter holds 3
        drive(2'b01, 2'b01, 1'b0, 30'h200, 2'b01, 2'b00, 32'h600DCAFE);
        step();
        chk("sat_ack_a",  32'(ack_a), 32'h1);
        chk("sat_miso_a", miso_a[31:0], 32'h600DCAFE);
        drive(2'b01, 2'b01, 1'b0, 30'h200, 2'b00, 2'b00, 32'h0);
        step();
        chk("sat_ack_off", 32'(ack_a), 32'h0);
        idle();
        step();
        $display("[TB] saturation txn_a=%0d txn_b=%0d", txn_a[15:0], txn_b[1:0]);
        chk("sat_txn_a", 32'(txn_a[15:0]), 32'd5);
        chk("sat_txn_b", 32'(txn_b[1:0]), 32'd3);

        // Asynchronous reset while a request sits in WAIT
        drive(2'b01, 2'b01, 1'b0, 30'h200, 2'b00, 2'b00, 32'h31313131);
        step();
        step();
        #3;
        reset_n = 1'b0;
        #1;
        $display("[TB] async reset txn_a=%0d viol_a=%b ack_a=%b", txn_a[15:0], viol_a, ack_a);
        chk("arst_txn_a",   txn_a, 32'h0);
        chk("arst_abort_a", abort_a, 32'h0);
        chk("arst_txn_b",   32'(txn_b), 32'h0);
        chk("arst_viol",    32'({viol_a, viol_b}), 32'h0);
        chk("arst_resp",    32'({err_a, ack_a, err_b, ack_b}), 32'h0);
        idle();
        step();
        step();
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("post_rst_quiet%0d", k), 32'({err_a, ack_a}), 32'h0);
        end
        chk("post_rst_abort", abort_a, 32'h0);

        // Latency bound after reset: ACK exactly 4 edges after the request
        drive(2'b01, 2'b01, 1'b0, 30'h200, 2'b00, 2'b00, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("max_lat_t%0d", k), 32'(ack_a), (k == 4) ? 32'h1 : 32'h0);
        end
        drive(2'b01, 2'b01, 1'b0, 30'h200, 2'b00, 2'b00, 32'h0);
        step();
        chk("max_lat_single", 32'(ack_a), 32'h0);
        idle();
        step();
        chk("max_lat_txn", 32'(txn_a[15:0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_bus_responder.md
# wb_bus_responder

Parametrised multi-channel Wishbone classic slave responder for the formal and simulation harnesses around the core. Each channel answers one master bus (instruction, data, or extra ports) with nondeterministic or bench-driven wait states and a guaranteed upper latency bound. It can optionally inject ERR responses and flags master-side protocol violations. One instance replaces the per-bus hand-written ACK assumptions and fairness counters in core wrappers.

## Interface

Parameters:
- NUM_CHANNELS, 2, number of independent Wishbone buses served
- ADDR_W, 30, word-address width per channel
- DATA_W, 32, data width per channel; SEL width is DATA_W/8
- MAX_WAIT, 3, wait-state bound; the response is forced when the wait counter equals MAX_WAIT (0 = always respond at minimum latency)
- ERR_ENABLE, 0, 1 allows ERR responses from rand_err
- CNT_W, 16, width of the per-channel saturating transaction counters

Ports (channel c occupies slice [c*W +: W] of each packed vector):
- clock, input, 1, sole clock
- reset_n, input, 1, asynchronous active-low reset
- wb_cyc, input, NUM_CHANNELS, master CYC
- wb_stb, input, NUM_CHANNELS, master STB
- wb_we, input, NUM_CHANNELS, master WE
- wb_adr, input, NUM_CHANNELS*ADDR_W, master ADR
- wb_sel, input, NUM_CHANNELS*DATA_W/8, master SEL
- wb_dat_mosi, input, NUM_CHANNELS*DATA_W, write data (captured only, for the checker)
- rand_ack, input, NUM_CHANNELS, free/bench choice to respond this cycle
- rand_err, input, NUM_CHANNELS, free/bench choice that the response is ERR
- rand_data, input, NUM_CHANNELS*DATA_W, read data offered this cycle
- wb_ack, output, NUM_CHANNELS, registered ACK
- wb_err, output, NUM_CHANNELS, registered ERR
- wb_dat_miso, output, NUM_CHANNELS*DATA_W, registered read data
- violation, output, NUM_CHANNELS, sticky protocol-violation flag
- txn_count, output, NUM_CHANNELS*CNT_W, completed responses, saturating
- abort_count, output, NUM_CHANNELS*CNT_W, CYC drops while pending, saturating

## Operation

- Channels are fully independent; there is no shared state.
- Per-channel FSM states:
  - IDLE: no request pending.
  - WAIT: request pending, wait_cnt counting.
  - RESP: ACK or ERR high.
- A request is cyc&stb.
- Response decision `go` = rand_ack | (wait_cnt == MAX_WAIT).
- The response is ERR if ERR_ENABLE & rand_err, otherwise ACK.
- IDLE:
  - With a request, the channel captures adr/we/sel/dat_mosi.
  - If `go` (wait_cnt taken as 0), it goes to RESP. Otherwise it goes to WAIT with wait_cnt=1.
- WAIT:
  - If cyc is low, the channel goes to IDLE, abort_count increments, and no response is issued.
  - Else if `go`, it goes to RESP.
  - Otherwise wait_cnt increments. wait_cnt never exceeds MAX_WAIT.
- RESP:
  - Exactly one of wb_ack/wb_err is high for one cycle.
  - wb_dat_miso = rand_data latched at the decision cycle for reads, and 0 for writes or ERR.
  - txn_count increments, saturating at all-ones.
  - Next state is IDLE. Back-to-back requests therefore see one IDLE cycle minimum.
- Outside RESP: wb_ack=0, wb_err=0, wb_dat_miso=0.
- Violation becomes 1 and stays set until reset in any of these cases:
  - in WAIT, stb low while cyc high;
  - in WAIT, adr/we/sel/dat_mosi differ from the captured values;
  - stb high while cyc low, in any state.
- Reset mid-transaction: reset_n low forces everything to reset values asynchronously. A pending request is dropped and counts nothing.

## Timing

- Reset values: all outputs 0, FSM IDLE, wait_cnt 0, counters 0, violation 0.
- Minimum latency: request in cycle t with rand_ack=1 gives ACK in cycle t+1.
- Maximum latency: ACK or ERR no later than t+1+MAX_WAIT while cyc stays high.
- ACK/ERR never assert in a cycle following a cycle with cyc low.
- Simultaneous cyc drop and `go` in WAIT: the abort wins, with no response.
- Simultaneous rand_ack and rand_err with ERR_ENABLE=1: ERR wins.

## Structure

- Package wb_resp_pkg: FSM state enum {IDLE, WAIT, RESP} and a wait-counter width function $clog2(MAX_WAIT+1), minimum 1.
- Sub-module wb_resp_channel: one channel (FSM, capture registers, counters, checker). The top level is a generate loop plus slicing.

## Test plan

- MAX_WAIT=3, ch0: request at t=0 with rand_ack=1 and rand_data=32'hDEADBEEF (read) -> wb_ack[0]=1 at t=1 only; wb_dat_miso=32'hDEADBEEF; txn_count[0]=1.
- MAX_WAIT=3, rand_ack held 0 -> ACK at exactly t=4; wb_ack never high for 2 consecutive cycles.
- ERR_ENABLE=1, rand_ack=1 and rand_err=1 at t=2 -> wb_err=1 and wb_ack=0 at t=3; wb_dat_miso=0. With ERR_ENABLE=0 the same stimulus gives ACK.
- cyc dropped at t=2 while in WAIT, rand_ack=1 the same cycle -> no ACK; abort_count=1; txn_count unchanged.
- ADR changed at t=1 during WAIT on ch1 only -> violation=2'b10, still set after 10 further cycles; ch0 unaffected.
- reset_n pulsed low mid-WAIT and CNT_W=2 saturation after 5 transactions -> outputs 0 immediately on reset; txn_count stays 2'b11 after 5 transactions.
